library_checker: RTL and testbench

- Downstream consumer of the gate-library test bench; samples the library cell outputs (NOT, NAND, NOR, MUX, flop Q/Qn) on every enabled CLK edge.
- Compares each sample against an internal golden model built from the same stimulus (iA, iB, SEL, D).
- Keeps per-output toggle (power) counters, error statistics, and first-failure capture.
- All counters are readable through a select/readback port.

---
 rtl/library_pkg.sv | 30 +++
 rtl/sat_counter.sv | 28 ++
 rtl/library_checker.sv | 171 +++++++++++++++++
 tb/tb_library_checker.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/library_pkg.sv
// Shared definitions for the gate-library checker.
// - FSM state encoding
// - mismatch-vector bit positions (also the toggle counter order)
// - readback select codes
package library_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam int NUM_OUT = 6;
  localparam int MM_NOT  = 0;
  localparam int MM_NAND = 1;
  localparam int MM_NOR  = 2;
  localparam int MM_MUX  = 3;
  localparam int MM_Q    = 4;
  localparam int MM_QN   = 5;

  // Readback codes 0..5 select toggle counters in mismatch bit order.
  localparam logic [2:0] RD_TOG_NOT  = 3'd0;
  localparam logic [2:0] RD_TOG_NAND = 3'd1;
  localparam logic [2:0] RD_TOG_NOR  = 3'd2;
  localparam logic [2:0] RD_TOG_MUX  = 3'd3;
  localparam logic [2:0] RD_TOG_Q    = 3'd4;
  localparam logic [2:0] RD_TOG_QN   = 3'd5;
  localparam logic [2:0] RD_ERR      = 3'd6;
  localparam logic [2:0] RD_SMP      = 3'd7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// - clk, rst : clock, async active-high reset
// - inc      : add one this edge (ignored once at all-ones)
// - cnt      : current count
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/library_checker.sv
// Checker for the gate-library cells (NOT, NAND, NOR, MUX, flop Q/Qn).
// Samples the cell outputs on every enabled CLK edge, compares them with a
// golden model driven by the same stimulus, and keeps toggle counters,
// error statistics and first-failure capture.
// - CLK, RESET          : clock, async active-high reset
// - ENB                 : sampling enable (also the DUT flop enable)
// - iA, iB, SEL, D      : stimulus shared with the DUT
// - NOT..Qn             : DUT outputs under check
// - RD_SEL / CNT_DATA   : counter readback, registered, one cycle latency
// - ERR, ERR_CNT        : sticky mismatch flag, saturating mismatch count
// - HALTED              : error limit reached, everything frozen
// - FIRST_ERR_VEC/_SMP  : mismatch vector and sample index of first failure
module library_checker
  import library_pkg::*;
#(
  parameter int CW        = 16,
  parameter int ERR_LIMIT = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENB,
  input  logic          iA,
  input  logic          iB,
  input  logic          SEL,
  input  logic          D,
  input  logic          NOT,
  input  logic          NAND,
  input  logic          NOR,
  input  logic          MUX,
  input  logic          Q,
  input  logic          Qn,
  input  logic [2:0]    RD_SEL,
  output logic [CW-1:0] CNT_DATA,
  output logic          ERR,
  output logic [CW-1:0] ERR_CNT,
  output logic          HALTED,
  output logic [5:0]    FIRST_ERR_VEC,
  output logic [CW-1:0] FIRST_ERR_SMP
);

  localparam int            NUM_CNT = NUM_OUT + 2;
  localparam logic [CW-1:0] LIM_M1  = CW'(ERR_LIMIT - 1);

  logic [1:0]         state_q, state_d;
  logic               q_ref_q, q_ref_d;
  logic               q_ref_valid_q, q_ref_valid_d;
  logic [NUM_OUT-1:0] prev_q, prev_d;
  logic               err_q, err_d;
  logic [5:0]         first_vec_q, first_vec_d;
  logic [CW-1:0]      first_smp_q, first_smp_d;
  logic [CW-1:0]      cnt_data_q, cnt_data_d;

  logic [NUM_OUT-1:0]          obs, exp_v, mm;
  logic [NUM_CNT-1:0]          cnt_inc;
  logic [NUM_CNT-1:0][CW-1:0]  cnt;
  logic                        sample, run_smp, err_inc, halt_hit;

  assign obs = {Qn, Q, MUX, NOR, NAND, NOT};

  always_comb begin
    exp_v          = '0;
    exp_v[MM_NOT]  = ~iA;
    exp_v[MM_NAND] = ~(iA & iB);
    exp_v[MM_NOR]  = ~(iA | iB);
    exp_v[MM_MUX]  = SEL ? iB : iA;
    exp_v[MM_Q]    = q_ref_q;
    exp_v[MM_QN]   = ~q_ref_q;
    // Case inequality so X/Z on a DUT output is flagged in simulation.
    mm = '0;
    for (int i = 0; i < NUM_OUT; i++) mm[i] = (obs[i] !== exp_v[i]);
    if (!q_ref_valid_q) begin
      mm[MM_Q]  = 1'b0;
      mm[MM_QN] = 1'b0;
    end
  end

  // An enabled edge seen from IDLE is the arming sample: compared and
  // counted, but it only seeds prev (state becomes ARM afterwards).
  // Enabled edges from ARM/RUN also count toggles.
  assign sample   = ENB && (state_q != ST_HALT);
  assign run_smp  = sample && ((state_q == ST_ARM) || (state_q == ST_RUN));
  assign err_inc  = sample && (|mm);
  assign halt_hit = (ERR_LIMIT != 0) && err_inc && (cnt[RD_ERR] == LIM_M1);

  always_comb begin
    cnt_inc = '0;
    for (int i = 0; i < NUM_OUT; i++) cnt_inc[i] = run_smp && (obs[i] !== prev_q[i]);
    cnt_inc[RD_ERR] = err_inc;
    cnt_inc[RD_SMP] = sample;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_cnt
      sat_counter #(.CW(CW)) u_cnt (
        .clk (CLK),
        .rst (RESET),
        .inc (cnt_inc[g]),
        .cnt (cnt[g])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (ENB) state_d = ST_ARM;
      ST_ARM, ST_RUN: state_d = ENB ? ST_RUN : ST_IDLE;
      default:        state_d = ST_HALT;
    endcase
    if (halt_hit) state_d = ST_HALT;

    q_ref_d       = q_ref_q;
    q_ref_valid_d = q_ref_valid_q;
    if (ENB) begin
      q_ref_d       = D;
      q_ref_valid_d = 1'b1;
    end

    prev_d = sample ? obs : prev_q;

    err_d       = err_q | err_inc;
    first_vec_d = first_vec_q;
    first_smp_d = first_smp_q;
    if (err_inc && !err_q) begin
      first_vec_d = mm;
      first_smp_d = cnt[RD_SMP];
    end

    case (RD_SEL)
      RD_TOG_NOT:  cnt_data_d = cnt[MM_NOT];
      RD_TOG_NAND: cnt_data_d = cnt[MM_NAND];
      RD_TOG_NOR:  cnt_data_d = cnt[MM_NOR];
      RD_TOG_MUX:  cnt_data_d = cnt[MM_MUX];
      RD_TOG_Q:    cnt_data_d = cnt[MM_Q];
      RD_TOG_QN:   cnt_data_d = cnt[MM_QN];
      RD_ERR:      cnt_data_d = cnt[RD_ERR];
      default:     cnt_data_d = cnt[RD_SMP];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      q_ref_q       <= 1'b0;
      q_ref_valid_q <= 1'b0;
      prev_q        <= '0;
      err_q         <= 1'b0;
      first_vec_q   <= '0;
      first_smp_q   <= '0;
      cnt_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      q_ref_q       <= q_ref_d;
      q_ref_valid_q <= q_ref_valid_d;
      prev_q        <= prev_d;
      err_q         <= err_d;
      first_vec_q   <= first_vec_d;
      first_smp_q   <= first_smp_d;
      cnt_data_q    <= cnt_data_d;
    end
  end

  assign CNT_DATA      = cnt_data_q;
  assign ERR           = err_q;
  assign ERR_CNT       = cnt[RD_ERR];
  assign HALTED        = (state_q == ST_HALT);
  assign FIRST_ERR_VEC = first_vec_q;
  assign FIRST_ERR_SMP = first_smp_q;

endmodule

// File: tb/tb_library_checker.sv
module tb_library_checker;

  logic        CLK = 1'b0, RESET = 1'b0, ENB = 1'b0;
  logic        iA = 1'b0, iB = 1'b0, SEL = 1'b0, D = 1'b0;
  logic [2:0]  RD_SEL = 3'd0;
  logic [15:0] CNT_DATA, ERR_CNT, FIRST_ERR_SMP;
  logic        ERR, HALTED;
  logic [5:0]  FIRST_ERR_VEC;

  // Behavioural gate library with fault knobs.
  logic nand_bad = 1'b0, mux_a = 1'b0, q_stuck0 = 1'b0;
  logic dut_q;
  logic w_not, w_nand, w_nor, w_mux, w_q, w_qn;
  assign w_not  = ~iA;
  assign w_nand = nand_bad ? (iA & iB) : ~(iA & iB);
  assign w_nor  = ~(iA | iB);
  assign w_mux  = mux_a ? iA : (SEL ? iB : iA);
  assign w_q    = dut_q;
  assign w_qn   = ~dut_q;
  always @(posedge CLK or posedge RESET)
    if (RESET) dut_q <= 1'b0;
    else if (ENB) dut_q <= q_stuck0 ? 1'b0 : D;

  int n_chk = 0, n_err = 0;

  always #5 CLK = ~CLK;

  library_checker #(.CW(16), .ERR_LIMIT(8)) dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .iA(iA), .iB(iB), .SEL(SEL), .D(D),
    .NOT(w_not), .NAND(w_nand), .NOR(w_nor), .MUX(w_mux), .Q(w_q), .Qn(w_qn),
    .RD_SEL(RD_SEL), .CNT_DATA(CNT_DATA), .ERR(ERR), .ERR_CNT(ERR_CNT),
    .HALTED(HALTED), .FIRST_ERR_VEC(FIRST_ERR_VEC), .FIRST_ERR_SMP(FIRST_ERR_SMP)
  );

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic reset_dut();
    ENB = 0; iA = 0; iB = 0; SEL = 0; D = 0; RD_SEL = 0;
    nand_bad = 0; mux_a = 0; q_stuck0 = 0;
    @(negedge CLK); RESET = 1; #2; RESET = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_chk++; if (ERR !== 1'b0)        begin n_err++; $display("FAIL rst_err got %b want 0", ERR); end
    n_chk++; if (ERR_CNT !== 16'd0)   begin n_err++; $display("FAIL rst_errcnt got %0d want 0", ERR_CNT); end
    n_chk++; if (HALTED !== 1'b0)     begin n_err++; $display("FAIL rst_halted got %b want 0", HALTED); end
    n_chk++; if (CNT_DATA !== 16'd0)  begin n_err++; $display("FAIL rst_cntdata got %0d want 0", CNT_DATA); end
    n_chk++; if (FIRST_ERR_VEC !== 6'd0) begin n_err++; $display("FAIL rst_fvec got %b want 0", FIRST_ERR_VEC); end
    n_chk++; if (FIRST_ERR_SMP !== 16'd0) begin n_err++; $display("FAIL rst_fsmp got %0d want 0", FIRST_ERR_SMP); end
  endtask

  task automatic test_gates();
    logic [15:0] exp_rd [7];
    exp_rd = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0};
    reset_dut();
    ENB = 1;
    for (int i = 0; i < 4; i++) begin
      {iA, iB} = 2'(i);
      step();
    end
    n_chk++; if (ERR !== 1'b0)      begin n_err++; $display("FAIL gates_err got %b want 0", ERR); end
    n_chk++; if (ERR_CNT !== 16'd0) begin n_err++; $display("FAIL gates_errcnt got %0d want 0", ERR_CNT); end
    ENB = 0; RD_SEL = 3'd7; step();
    n_chk++; if (CNT_DATA !== 16'd4) begin n_err++; $display("FAIL gates_smp got %0d want 4", CNT_DATA); end
    for (int i = 0; i < 7; i++) begin
      RD_SEL = 3'(i); step();
      n_chk++; if (CNT_DATA !== exp_rd[i])
        begin n_err++; $display("FAIL gates_rd%0d got %0d want %0d", i, CNT_DATA, exp_rd[i]); end
    end
  endtask

  task automatic test_mux();
    reset_dut();
    mux_a = 1; ENB = 1; iB = 0;
    for (int i = 0; i < 4; i++) begin
      {SEL, iA} = 2'(i);
      step();
    end
    n_chk++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL mux_err got %b want 1", ERR); end
    n_chk++; if (ERR_CNT !== 16'd1) begin n_err++; $display("FAIL mux_errcnt got %0d want 1", ERR_CNT); end
    n_chk++; if (FIRST_ERR_VEC !== 6'b001000) begin n_err++; $display("FAIL mux_fvec got %b want 001000", FIRST_ERR_VEC); end
    n_chk++; if (FIRST_ERR_SMP !== 16'd3) begin n_err++; $display("FAIL mux_fsmp got %0d want 3", FIRST_ERR_SMP); end
  endtask

  task automatic test_flop();
    reset_dut();
    ENB = 1;
    for (int k = 0; k < 10; k++) begin D = k[0]; step(); end
    n_chk++; if (ERR_CNT !== 16'd0) begin n_err++; $display("FAIL flop_ok_errcnt got %0d want 0", ERR_CNT); end
    ENB = 0; RD_SEL = 3'd4; step();
    n_chk++; if (CNT_DATA !== 16'd8) begin n_err++; $display("FAIL flop_qtog got %0d want 8", CNT_DATA); end
    reset_dut();
    q_stuck0 = 1; ENB = 1;
    for (int k = 0; k < 10; k++) begin D = k[0]; step(); end
    n_chk++; if (ERR_CNT !== 16'd4) begin n_err++; $display("FAIL flop_bad_errcnt got %0d want 4", ERR_CNT); end
    n_chk++; if (FIRST_ERR_VEC !== 6'b110000) begin n_err++; $display("FAIL flop_fvec got %b want 110000", FIRST_ERR_VEC); end
    n_chk++; if (FIRST_ERR_SMP !== 16'd2) begin n_err++; $display("FAIL flop_fsmp got %0d want 2", FIRST_ERR_SMP); end
  endtask

  task automatic test_halt();
    reset_dut();
    nand_bad = 1; ENB = 1;
    for (int i = 0; i < 7; i++) step();
    n_chk++; if (HALTED !== 1'b0)   begin n_err++; $display("FAIL halt_early got %b want 0", HALTED); end
    n_chk++; if (ERR_CNT !== 16'd7) begin n_err++; $display("FAIL halt_cnt7 got %0d want 7", ERR_CNT); end
    step();
    n_chk++; if (HALTED !== 1'b1)   begin n_err++; $display("FAIL halt_set got %b want 1", HALTED); end
    n_chk++; if (ERR_CNT !== 16'd8) begin n_err++; $display("FAIL halt_cnt8 got %0d want 8", ERR_CNT); end
    RD_SEL = 3'd7;
    for (int i = 0; i < 5; i++) step();
    n_chk++; if (ERR_CNT !== 16'd8)  begin n_err++; $display("FAIL halt_frozen got %0d want 8", ERR_CNT); end
    n_chk++; if (CNT_DATA !== 16'd8) begin n_err++; $display("FAIL halt_smp got %0d want 8", CNT_DATA); end
    n_chk++; if (HALTED !== 1'b1)    begin n_err++; $display("FAIL halt_stay got %b want 1", HALTED); end
    n_chk++; if (FIRST_ERR_VEC !== 6'b000010) begin n_err++; $display("FAIL halt_fvec got %b want 000010", FIRST_ERR_VEC); end
  endtask

  task automatic test_enb_gap();
    reset_dut();
    ENB = 1;
    iA = 0; step(); iA = 1; step(); iA = 0; step();
    ENB = 0; iA = 1; RD_SEL = 3'd7; step();
    n_chk++; if (CNT_DATA !== 16'd3) begin n_err++; $display("FAIL gap_smp1 got %0d want 3", CNT_DATA); end
    iA = 0; RD_SEL = 3'd0; step();
    n_chk++; if (CNT_DATA !== 16'd2) begin n_err++; $display("FAIL gap_tog1 got %0d want 2", CNT_DATA); end
    iA = 1; RD_SEL = 3'd7; step();
    n_chk++; if (CNT_DATA !== 16'd3) begin n_err++; $display("FAIL gap_smp2 got %0d want 3", CNT_DATA); end
    ENB = 1; iA = 1; RD_SEL = 3'd0; step();
    ENB = 0; step();
    n_chk++; if (CNT_DATA !== 16'd2) begin n_err++; $display("FAIL gap_rearm_tog got %0d want 2", CNT_DATA); end
    RD_SEL = 3'd7; step();
    n_chk++; if (CNT_DATA !== 16'd4) begin n_err++; $display("FAIL gap_smp3 got %0d want 4", CNT_DATA); end
    n_chk++; if (ERR !== 1'b0) begin n_err++; $display("FAIL gap_err got %b want 0", ERR); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    nand_bad = 1; ENB = 1; RD_SEL = 3'd7;
    iA = 0; step(); iA = 1; step(); iA = 0; step();
    n_chk++; if (ERR_CNT !== 16'd3)  begin n_err++; $display("FAIL ar_pre_cnt got %0d want 3", ERR_CNT); end
    n_chk++; if (CNT_DATA !== 16'd2) begin n_err++; $display("FAIL ar_pre_rd got %0d want 2", CNT_DATA); end
    #2; RESET = 1; #1;
    n_chk++; if (ERR !== 1'b0)       begin n_err++; $display("FAIL ar_err got %b want 0", ERR); end
    n_chk++; if (ERR_CNT !== 16'd0)  begin n_err++; $display("FAIL ar_cnt got %0d want 0", ERR_CNT); end
    n_chk++; if (CNT_DATA !== 16'd0) begin n_err++; $display("FAIL ar_rd got %0d want 0", CNT_DATA); end
    n_chk++; if (FIRST_ERR_VEC !== 6'd0) begin n_err++; $display("FAIL ar_fvec got %b want 0", FIRST_ERR_VEC); end
    #1; RESET = 0;
    nand_bad = 0; iA = 0; RD_SEL = 3'd0; step();
    ENB = 0; step();
    n_chk++; if (CNT_DATA !== 16'd0) begin n_err++; $display("FAIL ar_arm_tog got %0d want 0", CNT_DATA); end
    RD_SEL = 3'd7; step();
    n_chk++; if (CNT_DATA !== 16'd1) begin n_err++; $display("FAIL ar_arm_smp got %0d want 1", CNT_DATA); end
    n_chk++; if (ERR !== 1'b0) begin n_err++; $display("FAIL ar_post_err got %b want 0", ERR); end
  endtask

  initial begin
    test_reset();
    test_gates();
    test_mux();
    test_flop();
    test_halt();
    test_enb_gap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
